seq_divider: RTL and testbench
==============================

# seq_divider

Iterative restoring unsigned divider, N-bit dividend by N-bit divisor. Produces quotient and remainder in one-bit-per-cycle steps. Each step is a trial subtraction using the same ripple add/subtract arithmetic as the team's adder-subtractor. It undoes a multiplication in the same way the subtract path undoes addition, and it serves datapaths that cannot afford a combinational array divider.

## Interface
- N, default 8, operand/result width (N ≥ 2)
- clk_i  input  1  clock, all state updates on rising edge
- rst_i  input  1  asynchronous, active-high reset
- start_i  input  1  request; sampled only in IDLE
- dividend_i  input  N  dividend, captured with start_i
- divisor_i  input  N  divisor, captured with start_i
- busy_o  output  1  high while iterating (RUN)
- done_o  output  1  one-cycle pulse, results valid
- quotient_o  output  N  quotient
- remainder_o  output  N  remainder
- div_by_zero_o  output  1  captured divisor was zero; valid with done_o

## Operation
- States: IDLE, RUN, DONE.
- IDLE:
  - start_i=1 → capture operands; rem←0, quo←dividend_i, cnt←0; div_by_zero flag←(divisor_i==0).
  - Go to RUN, or to DONE under the fast-zero path (see Configuration).
  - start_i=0 → stay.
- RUN, one iteration per edge:
  - {rem,quo} shifted left by 1.
  - trial = shifted rem (N+1 bits) − divisor, computed N+1 bits wide, no overflow.
  - trial non-negative → rem←trial[N-1:0], quo[0]←1. Otherwise rem keeps the shifted value, quo[0]←0.
  - cnt increments. After the iteration with cnt==N-1, go to DONE.
- DONE: done_o=1 for exactly one cycle. Next edge → IDLE unconditionally.
- Results:
  - quotient_o/remainder_o/div_by_zero_o update only on entry to DONE.
  - They hold until the next entry to DONE. Intermediate values are never visible.
- Divide by zero: the algorithm yields quotient = all ones and remainder = dividend. The fast-zero path produces the same values.
- start_i in RUN or DONE is ignored, not queued. Operand inputs are don't-care except at the capture edge.

## Timing
- Reset values: state IDLE; busy_o=0, done_o=0, quotient_o=0, remainder_o=0, div_by_zero_o=0; cnt=0.
- start_i sampled high at edge k, normal divisor:
  - busy_o=1 during cycles after edges k … k+N-1.
  - done_o=1 in the cycle after edge k+N.
  - Total latency N+1 edges from capture to done. busy_o=0 when done_o=1.
- Earliest next capture is edge k+N+2, the first edge seen in IDLE.
- Reset asserted mid-operation aborts immediately: no done_o pulse, results cleared to 0.
- Back-to-back: holding start_i high gives one operation every N+2 cycles.

## Configuration
- DIV_ZERO_FAST_EN defined:
  - Zero divisor at capture → IDLE goes directly to DONE.
  - done_o appears in the cycle after edge k+1.
  - quotient_o = all ones, remainder_o = dividend, div_by_zero_o=1. busy_o never asserts.
- DIV_ZERO_FAST_EN undefined:
  - Zero divisor runs the full N iterations with normal latency.
  - Result values are identical and div_by_zero_o=1.

## Test plan
- N=8, reset, then 100/7 → done_o exactly 9 edges after capture; quotient_o=14, remainder_o=2, div_by_zero_o=0; busy_o high for exactly 8 cycles.
- 255/1 then 5/9 back-to-back with start_i held high → (255,0), then (0,5); second done_o exactly 10 cycles after the first.
- 37/0 → quotient_o=0xFF, remainder_o=37, div_by_zero_o=1. done_o 2 edges after capture with DIV_ZERO_FAST_EN, 9 edges without.
- 200/13 started, then start_i pulsed with 50/5 during RUN → only (15,5) reported, single done_o; the second request is ignored.
- 100/7 started, rst_i asserted asynchronously after 4 iterations → all outputs 0 immediately, no done_o. After release, 9/3 → (3,0).
- Random sweep of 1000 operand pairs plus corners (0/x, x/x, 255/255, 1/255) → quotient×divisor+remainder==dividend and remainder<divisor for nonzero divisors.

Source files
------------

// File: rtl/seq_divider.sv
// Iterative restoring unsigned divider, one quotient bit per cycle; optional DIV_ZERO_FAST_EN shortcut.
// Latency N+1 edges capture-to-done (2 with fast zero path); start_i is ignored while RUN/DONE.
// Backpressure: none -- results hold until the next done_o, new requests are accepted only in IDLE.
module seq_divider #(
    parameter int N = 8
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         start_i,
    input  logic [N-1:0] dividend_i,
    input  logic [N-1:0] divisor_i,
    output logic         busy_o,
    output logic         done_o,
    output logic [N-1:0] quotient_o,
    output logic [N-1:0] remainder_o,
    output logic         div_by_zero_o
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam int CW = (N > 2) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    state_t         state;
    logic [N-1:0]   rem;
    logic [N-1:0]   quo;
    logic [N-1:0]   dvsr;
    logic [CW-1:0]  cnt;
    logic           dz;

    logic [N:0]     rem_sh;
    logic [N:0]     trial;
    logic [N-1:0]   rem_nx;
    logic [N-1:0]   quo_nx;

    // Trial subtraction is one bit wider than the operands, so its MSB is the borrow.
    always_comb begin
        rem_sh = {rem, quo[N-1]};
        trial  = rem_sh - {1'b0, dvsr};
        rem_nx = trial[N] ? rem_sh[N-1:0] : trial[N-1:0];
        quo_nx = {quo[N-2:0], ~trial[N]};
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state         <= IDLE;
            rem           <= '0;
            quo           <= '0;
            dvsr          <= '0;
            cnt           <= '0;
            dz            <= 1'b0;
            busy_o        <= 1'b0;
            done_o        <= 1'b0;
            quotient_o    <= '0;
            remainder_o   <= '0;
            div_by_zero_o <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done_o <= 1'b0;
                    if (start_i) begin
                        rem  <= '0;
                        quo  <= dividend_i;
                        dvsr <= divisor_i;
                        cnt  <= '0;
                        dz   <= (divisor_i == '0);
`ifdef DIV_ZERO_FAST_EN
                        if (divisor_i == '0) begin
                            state <= DONE;
                        end else begin
                            state  <= RUN;
                            busy_o <= 1'b1;
                        end
`else
                        state  <= RUN;
                        busy_o <= 1'b1;
`endif
                    end
                end
                RUN: begin
                    rem <= rem_nx;
                    quo <= quo_nx;
                    cnt <= cnt + CW'(1);
                    if (cnt == LAST) begin
                        state         <= DONE;
                        busy_o        <= 1'b0;
                        done_o        <= 1'b1;
                        quotient_o    <= quo_nx;
                        remainder_o   <= rem_nx;
                        div_by_zero_o <= dz;
                    end
                end
                DONE: begin
`ifdef DIV_ZERO_FAST_EN
                    // Fast zero entry arrives with done_o low; quo still holds the dividend.
                    if (!done_o) begin
                        done_o        <= 1'b1;
                        quotient_o    <= '1;
                        remainder_o   <= quo;
                        div_by_zero_o <= 1'b1;
                    end else begin
                        done_o <= 1'b0;
                        state  <= IDLE;
                    end
`else
                    done_o <= 1'b0;
                    state  <= IDLE;
`endif
                end
                default: begin
                    state  <= IDLE;
                    busy_o <= 1'b0;
                    done_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider (N=8): driver queues expected results, monitor checks each done_o.
module tb_seq_divider;

    localparam int N = 8;

    logic         clk;
    logic         rst;
    logic         start;
    logic [N-1:0] dividend;
    logic [N-1:0] divisor;
    logic         busy;
    logic         done;
    logic [N-1:0] quotient;
    logic [N-1:0] remainder;
    logic         dbz;

    typedef struct {
        logic [N-1:0] q;
        logic [N-1:0] r;
        logic         dz;
        int           cyc;
        int           busy_cycles;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   done_seen = 0;
    int   busy_cnt = 0;

    seq_divider #(.N(N)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .start_i      (start),
        .dividend_i   (dividend),
        .divisor_i    (divisor),
        .busy_o       (busy),
        .done_o       (done),
        .quotient_o   (quotient),
        .remainder_o  (remainder),
        .div_by_zero_o(dbz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: every done_o must match the oldest queued expectation.
    always @(negedge clk) begin
        if (rst) begin
            busy_cnt = 0;
        end else begin
            if (busy) busy_cnt++;
            if (done) begin
                exp_t e;
                done_seen++;
                if (exp_q.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("quotient", int'(quotient), int'(e.q));
                    chk("remainder", int'(remainder), int'(e.r));
                    chk("div_by_zero", int'(dbz), int'(e.dz));
                    chk("done_cycle", cyc, e.cyc);
                    chk("busy_cycles", busy_cnt, e.busy_cycles);
                    chk("busy_at_done", int'(busy), 0);
                end
                busy_cnt = 0;
            end
        end
    end

    function automatic exp_t model(input logic [N-1:0] a, input logic [N-1:0] b, input int cap);
        exp_t e;
        e.dz = (b == 0);
        if (b == 0) begin
            e.q = '1;
            e.r = a;
`ifdef DIV_ZERO_FAST_EN
            e.cyc = cap + 1;
            e.busy_cycles = 0;
`else
            e.cyc = cap + N;
            e.busy_cycles = N;
`endif
        end else begin
            e.q = a / b;
            e.r = a % b;
            e.cyc = cap + N;
            e.busy_cycles = N;
        end
        return e;
    endfunction

    task automatic wait_done(input int target);
        int t;
        t = 0;
        while (done_seen < target && t < 60) begin
            @(negedge clk);
            t++;
        end
        if (done_seen < target) chk("done_timeout", done_seen, target);
    endtask

    // Drive one operation from a negedge while the DUT is idle; return once it is idle again.
    task automatic do_op(input logic [N-1:0] a, input logic [N-1:0] b, input exp_t e);
        int target;
        target = done_seen + 1;
        start = 1'b1;
        dividend = a;
        divisor = b;
        exp_q.push_back(e);
        @(negedge clk);
        start = 1'b0;
        dividend = 'x;
        divisor = 'x;
        wait_done(target);
        @(negedge clk);
    endtask

    task automatic op(input logic [N-1:0] a, input logic [N-1:0] b);
        do_op(a, b, model(a, b, cyc + 1));
    endtask

    task automatic op_hand(input logic [N-1:0] a, input logic [N-1:0] b,
                           input logic [N-1:0] q, input logic [N-1:0] r, input logic dz);
        exp_t e;
        e = model(a, b, cyc + 1);
        e.q = q;
        e.r = r;
        e.dz = dz;
        do_op(a, b, e);
    endtask

    initial begin
        int target;
        int cap;
        exp_t e;
        rst = 1'b1;
        start = 1'b0;
        dividend = '0;
        divisor = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_quotient", int'(quotient), 0);
        chk("rst_remainder", int'(remainder), 0);
        chk("rst_dbz", int'(dbz), 0);
        rst = 1'b0;
        @(negedge clk);

        op_hand(8'd100, 8'd7, 8'd14, 8'd2, 1'b0);

        // Back-to-back with start held: 255/1 then 5/9, captures N+2 edges apart.
        target = done_seen + 2;
        cap = cyc + 1;
        start = 1'b1;
        dividend = 8'd255;
        divisor = 8'd1;
        e = model(8'd255, 8'd1, cap);
        e.q = 8'd255; e.r = 8'd0;
        exp_q.push_back(e);
        e = model(8'd5, 8'd9, cap + N + 2);
        e.q = 8'd0; e.r = 8'd5;
        exp_q.push_back(e);
        @(negedge clk);
        dividend = 8'd5;
        divisor = 8'd9;
        wait_done(target - 1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        wait_done(target);
        @(negedge clk);

        op_hand(8'd37, 8'd0, 8'hFF, 8'd37, 1'b1);

        // Second request during RUN must be dropped.
        target = done_seen + 1;
        e = model(8'd200, 8'd13, cyc + 1);
        e.q = 8'd15; e.r = 8'd5;
        exp_q.push_back(e);
        start = 1'b1;
        dividend = 8'd200;
        divisor = 8'd13;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        start = 1'b1;
        dividend = 8'd50;
        divisor = 8'd5;
        @(negedge clk);
        start = 1'b0;
        wait_done(target);
        repeat (12) @(negedge clk);
        chk("ignored_start_done_count", done_seen, target);

        // Asynchronous reset after 4 iterations aborts without a done pulse.
        target = done_seen;
        start = 1'b1;
        dividend = 8'd100;
        divisor = 8'd7;
        @(posedge clk);
        repeat (4) @(posedge clk);
        #2;
        start = 1'b0;
        rst = 1'b1;
        #1;
        chk("abort_busy", int'(busy), 0);
        chk("abort_done", int'(done), 0);
        chk("abort_quotient", int'(quotient), 0);
        chk("abort_remainder", int'(remainder), 0);
        chk("abort_dbz", int'(dbz), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (12) @(negedge clk);
        chk("abort_no_done", done_seen, target);
        op_hand(8'd9, 8'd3, 8'd3, 8'd0, 1'b0);

        // Corners with hand-computed results.
        op_hand(8'd0, 8'd5, 8'd0, 8'd0, 1'b0);
        op_hand(8'd0, 8'd0, 8'hFF, 8'd0, 1'b1);
        op_hand(8'd77, 8'd77, 8'd1, 8'd0, 1'b0);
        op_hand(8'd255, 8'd255, 8'd1, 8'd0, 1'b0);
        op_hand(8'd1, 8'd255, 8'd0, 8'd1, 1'b0);
        op_hand(8'd254, 8'd16, 8'd15, 8'd14, 1'b0);

        for (int i = 0; i < 1000; i++) begin
            logic [N-1:0] a;
            logic [N-1:0] b;
            a = N'($urandom_range(0, 255));
            b = N'($urandom_range(0, 255));
            if (i % 50 == 0) b = '0;
            op(a, b);
        end

        repeat (5) @(negedge clk);
        chk("scoreboard_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
